// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: fetch constants, fetch FSM
// encodings and the IF/ID bundle.
package mips_pkg;

  localparam int          ILEN     = 32;
  localparam logic [31:0] NOP_WORD = 32'h0000_0000;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  localparam logic [1:0] FETCH_BOOT = 2'd0;
  localparam logic [1:0] FETCH_RUN  = 2'd1;
  localparam logic [1:0] FETCH_HALT = 2'd2;

  typedef struct packed {
    logic [ILEN-1:0] ins;
    logic [31:0]     pc4;
    logic            valid;
  } if_id_t;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register with stall hold and bubble flush.
// Flush wins over hold and leaves pc4 untouched.
module if_id_reg
  import mips_pkg::*;
#(
  parameter logic [31:0] NOP = mips_pkg::NOP_WORD
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   hold_i,
  input  logic   flush_i,
  input  if_id_t d_i,
  output if_id_t q_o
);

  if_id_t q_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_q.ins   <= NOP;
      q_q.pc4   <= '0;
      q_q.valid <= 1'b0;
    end else if (flush_i) begin
      q_q.ins   <= NOP;
      q_q.valid <= 1'b0;
    end else if (!hold_i) begin
      q_q <= d_i;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/instruction_fetch_unit.sv
// PC and fetch stage: next-PC mux, BOOT/RUN/HALT sequencing,
// out-of-range halting and the IF/ID register.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC  = mips_pkg::RESET_PC,
  parameter int          MEM_WORDS = 32,
  parameter logic [31:0] NOP_WORD  = mips_pkg::NOP_WORD
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_target,
  input  logic [31:0] ins,
  output logic [31:0] pc,
  output logic [31:0] if_id_ins,
  output logic [31:0] if_id_pc4,
  output logic        if_id_valid,
  output logic        halted
);

  import mips_pkg::*;

  localparam logic [31:0] PC_LIMIT = 32'(MEM_WORDS * 4);

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        halted_q, halted_d;
  logic [31:0] pc4;
  logic [31:0] tgt;
  logic        oor;
  logic        flush;
  if_id_t      ifid_d, ifid_q;

  assign pc4 = pc_q + 32'd4;
  assign tgt = {redirect_target[31:2], 2'b00};
  assign oor = pc_q >= PC_LIMIT;

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    halted_d = halted_q;
    flush    = 1'b1;
    unique case (state_q)
      FETCH_BOOT: begin
        state_d = FETCH_RUN;
        if (redirect) pc_d = tgt;
      end
      FETCH_RUN: begin
        if (redirect) begin
          pc_d = tgt;
        end else if (oor) begin
          halted_d = 1'b1;
          state_d  = FETCH_HALT;
        end else begin
          flush = 1'b0;
          if (!stall) pc_d = pc4;
        end
      end
      FETCH_HALT: begin
        if (redirect) begin
          pc_d     = tgt;
          halted_d = 1'b0;
          state_d  = FETCH_RUN;
        end
      end
      default: begin
        state_d  = FETCH_BOOT;
        halted_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= FETCH_BOOT;
      pc_q     <= RESET_PC;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      halted_q <= halted_d;
    end
  end

  assign ifid_d.ins   = ins;
  assign ifid_d.pc4   = pc4;
  assign ifid_d.valid = 1'b1;

  if_id_reg #(
    .NOP (NOP_WORD)
  ) u_if_id (
    .clk     (clk),
    .rst     (rst),
    .hold_i  (stall),
    .flush_i (flush),
    .d_i     (ifid_d),
    .q_o     (ifid_q)
  );

  assign pc          = pc_q;
  assign if_id_ins   = ifid_q.ins;
  assign if_id_pc4   = ifid_q.pc4;
  assign if_id_valid = ifid_q.valid;
  assign halted      = halted_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: directed plan
// scenarios plus randomized stall/redirect against a fetch model.
module tb_instruction_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_target;
  logic [31:0] ins;
  logic [31:0] pc;
  logic [31:0] if_id_ins;
  logic [31:0] if_id_pc4;
  logic        if_id_valid;
  logic        halted;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [32];

  // Model state: what decode should currently see.
  logic [31:0] m_pc, m_ins, m_pc4;
  logic        m_valid, m_halted, m_booted;

  instruction_fetch_unit dut (
    .clk             (clk),
    .rst             (rst),
    .stall           (stall),
    .redirect        (redirect),
    .redirect_target (redirect_target),
    .ins             (ins),
    .pc              (pc),
    .if_id_ins       (if_id_ins),
    .if_id_pc4       (if_id_pc4),
    .if_id_valid     (if_id_valid),
    .halted          (halted)
  );

  always #5 clk = ~clk;

  assign ins = (pc < 32'd128) ? mem[pc[6:2]] : 32'hDEAD_BEEF;

  wire [97:0] obs = {pc, if_id_ins, if_id_pc4, if_id_valid, halted};

  function automatic logic [97:0] exp_vec();
    return {m_pc, m_ins, m_pc4, m_valid, m_halted};
  endfunction

  task automatic m_reset();
    m_pc = 32'h0; m_ins = 32'h0; m_pc4 = 32'h0;
    m_valid = 1'b0; m_halted = 1'b0; m_booted = 1'b0;
  endtask

  task automatic m_edge();
    logic [31:0] t;
    t = redirect_target & ~32'h3;
    if (!m_booted) begin
      m_booted = 1'b1;
      if (redirect) m_pc = t;
    end else if (redirect) begin
      m_pc = t; m_ins = 32'h0; m_valid = 1'b0; m_halted = 1'b0;
    end else if (m_halted || m_pc >= 32'd128) begin
      m_halted = 1'b1; m_ins = 32'h0; m_valid = 1'b0;
    end else if (!stall) begin
      m_ins = mem[m_pc / 4]; m_pc4 = m_pc + 32'd4;
      m_valid = 1'b1; m_pc = m_pc + 32'd4;
    end
  endtask

  task automatic tick(input logic st, input logic rd,
                      input logic [31:0] tg);
    stall = st; redirect = rd; redirect_target = tg;
    @(posedge clk);
    m_edge();
    #1;
    stall = 1'b0; redirect = 1'b0;
  endtask

  task automatic test_reset();
    checks++;
    if (obs !== exp_vec()) begin
      errors++;
      $display("FAIL reset act=%h exp=%h", obs, exp_vec());
    end
    rst = 1'b1;
  endtask

  task automatic test_boot();
    tick(1'b0, 1'b0, 32'h0);
    checks++;
    if (pc !== 32'h0 || if_id_valid !== 1'b0 || obs !== exp_vec()) begin
      errors++;
      $display("FAIL boot_edge1 act=%h exp=%h", obs, exp_vec());
    end
    tick(1'b0, 1'b0, 32'h0);
    checks++;
    if (if_id_ins !== 32'h0088_5020 || if_id_pc4 !== 32'd4 ||
        pc !== 32'd4 || if_id_valid !== 1'b1 || obs !== exp_vec()) begin
      errors++;
      $display("FAIL boot_edge2 act=%h exp=%h", obs, exp_vec());
    end
  endtask

  task automatic test_steady();
    tick(1'b0, 1'b1, 32'h0);
    for (int k = 1; k <= 5; k++) begin
      tick(1'b0, 1'b0, 32'h0);
      checks++;
      if (if_id_pc4 !== 32'(4 * k) || if_id_ins !== mem[k-1] ||
          pc !== 32'(4 * k) || obs !== exp_vec()) begin
        errors++;
        $display("FAIL steady_%0d act=%h exp=%h", k, obs, exp_vec());
      end
    end
  endtask

  task automatic test_stall();
    tick(1'b0, 1'b1, 32'd8);
    tick(1'b0, 1'b0, 32'h0);
    tick(1'b0, 1'b1, 32'd8);
    for (int k = 0; k < 3; k++) begin
      tick(1'b1, 1'b0, 32'h0);
      checks++;
      if (pc !== 32'd8 || if_id_valid !== 1'b0 || obs !== exp_vec()) begin
        errors++;
        $display("FAIL stall_%0d act=%h exp=%h", k, obs, exp_vec());
      end
    end
    tick(1'b0, 1'b0, 32'h0);
    checks++;
    if (if_id_ins !== mem[2] || if_id_pc4 !== 32'd12 || pc !== 32'd12) begin
      errors++;
      $display("FAIL stall_resume act=%h exp=%h", obs, exp_vec());
    end
  endtask

  task automatic test_redirect_stall();
    tick(1'b0, 1'b1, 32'd16);
    tick(1'b1, 1'b1, 32'h0000_0002);
    checks++;
    if (pc !== 32'h0 || if_id_ins !== 32'h0 || if_id_valid !== 1'b0 ||
        obs !== exp_vec()) begin
      errors++;
      $display("FAIL redir_stall act=%h exp=%h", obs, exp_vec());
    end
    tick(1'b0, 1'b0, 32'h0);
    checks++;
    if (if_id_ins !== mem[0] || if_id_valid !== 1'b1 || pc !== 32'd4) begin
      errors++;
      $display("FAIL redir_next act=%h exp=%h", obs, exp_vec());
    end
  endtask

  task automatic test_halt();
    tick(1'b0, 1'b1, 32'd124);
    tick(1'b0, 1'b0, 32'h0);
    checks++;
    if (if_id_ins !== mem[31] || pc !== 32'd128 || halted !== 1'b0) begin
      errors++;
      $display("FAIL word31 act=%h exp=%h", obs, exp_vec());
    end
    for (int k = 0; k < 3; k++) begin
      tick(k == 2, 1'b0, 32'h0);
      checks++;
      if (halted !== 1'b1 || if_id_valid !== 1'b0 || pc !== 32'd128 ||
          obs !== exp_vec()) begin
        errors++;
        $display("FAIL halt_%0d act=%h exp=%h", k, obs, exp_vec());
      end
    end
    tick(1'b0, 1'b1, 32'h0);
    checks++;
    if (halted !== 1'b0 || pc !== 32'h0 || obs !== exp_vec()) begin
      errors++;
      $display("FAIL unhalt act=%h exp=%h", obs, exp_vec());
    end
    tick(1'b0, 1'b0, 32'h0);
    checks++;
    if (if_id_ins !== mem[0] || if_id_valid !== 1'b1) begin
      errors++;
      $display("FAIL unhalt_fetch act=%h exp=%h", obs, exp_vec());
    end
  endtask

  task automatic test_random();
    logic        st, rd;
    logic [31:0] tg;
    for (int i = 0; i < 400; i++) begin
      st = ($urandom_range(0, 99) < 30);
      rd = ($urandom_range(0, 99) < 8);
      tg = ($urandom_range(0, 9) == 0) ? $urandom
                                       : 32'($urandom_range(0, 140));
      tick(st, rd, tg);
      checks++;
      if (obs !== exp_vec()) begin
        errors++;
        $display("FAIL random_%0d act=%h exp=%h", i, obs, exp_vec());
      end
    end
  endtask

  task automatic test_async_reset();
    tick(1'b0, 1'b1, 32'd40);
    tick(1'b0, 1'b0, 32'h0);
    #2;
    rst = 1'b0;
    m_reset();
    #1;
    checks++;
    if (pc !== 32'h0 || if_id_valid !== 1'b0 || halted !== 1'b0 ||
        obs !== exp_vec()) begin
      errors++;
      $display("FAIL async_rst act=%h exp=%h", obs, exp_vec());
    end
    rst = 1'b1;
    tick(1'b0, 1'b0, 32'h0);
    tick(1'b0, 1'b0, 32'h0);
    checks++;
    if (if_id_ins !== mem[0] || pc !== 32'd4 || obs !== exp_vec()) begin
      errors++;
      $display("FAIL post_rst act=%h exp=%h", obs, exp_vec());
    end
  endtask

  initial begin
    rst = 1'b0;
    stall = 1'b0;
    redirect = 1'b0;
    redirect_target = 32'h0;
    mem[0] = 32'h0088_5020;
    for (int i = 1; i < 32; i++) mem[i] = $urandom;
    m_reset();
    #12;
    test_reset();
    test_boot();
    test_steady();
    test_stall();
    test_redirect_stall();
    test_halt();
    test_random();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
